// File: rtl/spi_regs_fifo_if.sv
// ----------------------------------------------------------------------------
// spi_regs_fifo_if
//   Peripheral-bus connection between the dbus fabric and the SPI register
//   block. The master side issues requests, the slave side acknowledges.
//
//   req     master -> slave  access request (level, qualified by spi_sel_i)
//   w_en    master -> slave  1 = write, 0 = read
//   addr    master -> slave  byte address, register offset in addr[7:0]
//   w_data  master -> slave  write data
//   ack     slave -> master  one-cycle acknowledge
//   r_data  slave -> master  read data, valid while ack is high
// ----------------------------------------------------------------------------
interface spi_regs_fifo_if;
    logic        req;
    logic        w_en;
    logic [31:0] addr;
    logic [31:0] w_data;
    logic        ack;
    logic [31:0] r_data;

    modport master (output req, w_en, addr, w_data, input ack, r_data);
    modport slave  (input req, w_en, addr, w_data, output ack, r_data);
endinterface

// File: rtl/spi_regs_fifo.sv
// ----------------------------------------------------------------------------
// spi_regs_fifo
//   SPI control/status register block with integrated TX and RX FIFOs.
//   Configuration writes land in shadow registers and are copied to the
//   outputs only while the controller is idle (spi_busy_i low) or, for the
//   chip-select group, while the CS lines are idle (spi_hold_off_i high).
//   Watermark interrupt pending bits come straight from FIFO occupancy.
//
//   Optional build macro SPI_ERR_IRQ_EN adds sticky TX/RX overflow pending
//   bits ip[2]/ip[3] (write-1-to-clear) with enables ie[3:2].
//
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     spi_sel_i         address decode select from the bus fabric
//     dbus              bus slave (req/w_en/addr/w_data -> ack/r_data)
//     irq_o             registered interrupt request
//     spi_busy_i        controller mid-frame, config outputs frozen
//     spi_hold_off_i    CS lines idle, CS outputs may update
//     tx_pop_i          datapath consumes TX head
//     tx_data_o         TX FIFO head, tx_empty_o TX FIFO empty
//     rx_push_i         datapath delivers rx_data_i, rx_full_o RX FIFO full
//     sck_div_o, sck_pha_o, sck_pol_o           clock divisor and mode
//     cs_id_o, cs_def_o, cs_mode_o              chip-select control
//     delay0_o {t2c,c2t}, delay1_o {interframe,intercs}
//     frame_len_o, shift_dir_o, rx_disable_o    frame format
// ----------------------------------------------------------------------------
module spi_regs_fifo #(
    parameter int  NUM_CS     = 4,
    parameter int  FIFO_DEPTH = 8,
    localparam int CSW        = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  spi_sel_i,
    spi_regs_fifo_if.slave        dbus,
    output logic                  irq_o,
    input  logic                  spi_busy_i,
    input  logic                  spi_hold_off_i,
    input  logic                  tx_pop_i,
    output logic [7:0]            tx_data_o,
    output logic                  tx_empty_o,
    input  logic                  rx_push_i,
    input  logic [7:0]            rx_data_i,
    output logic                  rx_full_o,
    output logic [11:0]           sck_div_o,
    output logic                  sck_pha_o,
    output logic                  sck_pol_o,
    output logic [CSW-1:0]        cs_id_o,
    output logic [NUM_CS-1:0]     cs_def_o,
    output logic [1:0]            cs_mode_o,
    output logic [15:0]           delay0_o,
    output logic [15:0]           delay1_o,
    output logic [3:0]            frame_len_o,
    output logic                  shift_dir_o,
    output logic                  rx_disable_o
);

    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [7:0] A_SCKDIV  = 8'h00;
    localparam logic [7:0] A_SCKMODE = 8'h04;
    localparam logic [7:0] A_CSID    = 8'h10;
    localparam logic [7:0] A_CSDEF   = 8'h14;
    localparam logic [7:0] A_CSMODE  = 8'h18;
    localparam logic [7:0] A_DELAY0  = 8'h28;
    localparam logic [7:0] A_DELAY1  = 8'h2C;
    localparam logic [7:0] A_FMT     = 8'h40;
    localparam logic [7:0] A_TXDATA  = 8'h48;
    localparam logic [7:0] A_RXDATA  = 8'h4C;
    localparam logic [7:0] A_TXMARK  = 8'h50;
    localparam logic [7:0] A_RXMARK  = 8'h54;
    localparam logic [7:0] A_IE      = 8'h70;
    localparam logic [7:0] A_IP      = 8'h74;

    logic              ack_q, irq_q;
    logic [31:0]       rData_q, rData_d;

    logic [11:0]       sckDivSh_q, sckDiv_q;
    logic [1:0]        sckModeSh_q, sckMode_q;
    logic [15:0]       delay0Sh_q, delay0_q, delay1Sh_q, delay1_q;
    logic [3:0]        fmtLenSh_q, fmtLen_q;
    logic              fmtDirSh_q, fmtDir_q, rxDisSh_q, rxDis_q;
    logic [CSW-1:0]    csIdSh_q, csId_q;
    logic [NUM_CS-1:0] csDefSh_q, csDef_q;
    logic [1:0]        csModeSh_q, csMode_q;
    logic [CW-1:0]     txMark_q, rxMark_q;
    logic [3:0]        ie_q;

    logic [7:0]        txMem_q [FIFO_DEPTH];
    logic [7:0]        rxMem_q [FIFO_DEPTH];
    logic [PW-1:0]     txWr_q, txRd_q, rxWr_q, rxRd_q;
    logic [CW-1:0]     txCount_q, rxCount_q;

    logic              accept, wrEn, rdEn;
    logic [7:0]        regAddr;
    logic              txFull, txEmpty, rxFull, rxEmpty;
    logic              txPush, txPop, rxPush, rxPop;
    logic              txOvf, rxOvf;
    logic [3:0]        ip;
    logic              unusedBits;

    // An access is taken only when no ack is outstanding, so back-to-back
    // requests are spaced at least two cycles apart.
    assign accept  = dbus.req & spi_sel_i & ~ack_q;
    assign wrEn    = accept & dbus.w_en;
    assign rdEn    = accept & ~dbus.w_en;
    assign regAddr = dbus.addr[7:0];

    assign txFull  = (txCount_q == CW'(FIFO_DEPTH));
    assign txEmpty = (txCount_q == '0);
    assign rxFull  = (rxCount_q == CW'(FIFO_DEPTH));
    assign rxEmpty = (rxCount_q == '0);

    // Full/empty are judged on the registered counts, so a push into a full
    // FIFO is dropped even if a pop happens in the same cycle.
    assign txPush  = wrEn & (regAddr == A_TXDATA) & ~txFull;
    assign txPop   = tx_pop_i & ~txEmpty;
    assign rxPush  = rx_push_i & ~rxFull & ~rxDis_q;
    assign rxPop   = rdEn & (regAddr == A_RXDATA) & ~rxEmpty;

    assign unusedBits = ^{dbus.addr, dbus.w_data};

`ifdef SPI_ERR_IRQ_EN
    logic txOvf_q, rxOvf_q;

    // Sticky overflow flags: a dropped push sets them, writing 1 to the
    // matching ip bit clears them; a drop in the clearing cycle wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txOvf_q <= 1'b0;
            rxOvf_q <= 1'b0;
        end else begin
            if (wrEn && regAddr == A_IP && dbus.w_data[2]) txOvf_q <= 1'b0;
            if (wrEn && regAddr == A_IP && dbus.w_data[3]) rxOvf_q <= 1'b0;
            if (wrEn && regAddr == A_TXDATA && txFull)     txOvf_q <= 1'b1;
            if (rx_push_i && rxFull && !rxDis_q)           rxOvf_q <= 1'b1;
        end
    end

    assign txOvf = txOvf_q;
    assign rxOvf = rxOvf_q;
`else
    assign txOvf = 1'b0;
    assign rxOvf = 1'b0;
`endif

    assign ip = {rxOvf, txOvf, (rxCount_q > rxMark_q), (txCount_q < txMark_q)};

    // Read data mux; the value is sampled at acceptance so an rxdata read
    // returns the head that is popped in that same cycle.
    always_comb begin
        rData_d = '0;
        case (regAddr)
            A_SCKDIV:  rData_d = 32'(sckDivSh_q);
            A_SCKMODE: rData_d = 32'(sckModeSh_q);
            A_CSID:    rData_d = 32'(csIdSh_q);
            A_CSDEF:   rData_d = 32'(csDefSh_q);
            A_CSMODE:  rData_d = 32'(csModeSh_q);
            A_DELAY0:  rData_d = {8'h00, delay0Sh_q[15:8], 8'h00, delay0Sh_q[7:0]};
            A_DELAY1:  rData_d = {8'h00, delay1Sh_q[15:8], 8'h00, delay1Sh_q[7:0]};
            A_FMT:     rData_d = {12'h000, fmtLenSh_q, 12'h000, rxDisSh_q, fmtDirSh_q, 2'b00};
            A_TXDATA:  rData_d = {txFull, 31'h0};
            A_RXDATA:  rData_d = {rxEmpty, 23'h0, rxEmpty ? 8'h00 : rxMem_q[rxRd_q]};
            A_TXMARK:  rData_d = 32'(txMark_q);
            A_RXMARK:  rData_d = 32'(rxMark_q);
            A_IE:      rData_d = 32'(ie_q);
            A_IP:      rData_d = 32'(ip);
            default:   rData_d = '0;
        endcase
    end

    // Bus response, interrupt register and all software-writable state.
    // Config registers written here are shadows; the live copies follow below.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q       <= 1'b0;
            rData_q     <= '0;
            irq_q       <= 1'b0;
            sckDivSh_q  <= 12'h003;
            sckModeSh_q <= 2'b00;
            csIdSh_q    <= '0;
            csDefSh_q   <= '1;
            csModeSh_q  <= 2'b00;
            delay0Sh_q  <= 16'h0101;
            delay1Sh_q  <= 16'h0001;
            fmtLenSh_q  <= 4'd8;
            fmtDirSh_q  <= 1'b0;
            rxDisSh_q   <= 1'b0;
            txMark_q    <= '0;
            rxMark_q    <= '0;
            ie_q        <= '0;
        end else begin
            ack_q   <= accept;
            rData_q <= rdEn ? rData_d : '0;
            irq_q   <= |(ie_q & ip);
            if (wrEn) begin
                case (regAddr)
                    A_SCKDIV:  sckDivSh_q  <= dbus.w_data[11:0];
                    A_SCKMODE: sckModeSh_q <= dbus.w_data[1:0];
                    A_CSID:    csIdSh_q    <= dbus.w_data[CSW-1:0];
                    A_CSDEF:   csDefSh_q   <= dbus.w_data[NUM_CS-1:0];
                    A_CSMODE:  csModeSh_q  <= dbus.w_data[1:0];
                    A_DELAY0:  delay0Sh_q  <= {dbus.w_data[23:16], dbus.w_data[7:0]};
                    A_DELAY1:  delay1Sh_q  <= {dbus.w_data[23:16], dbus.w_data[7:0]};
                    A_FMT: begin
                        fmtLenSh_q <= dbus.w_data[19:16];
                        rxDisSh_q  <= dbus.w_data[3];
                        fmtDirSh_q <= dbus.w_data[2];
                    end
                    A_TXMARK:  txMark_q <= dbus.w_data[CW-1:0];
                    A_RXMARK:  rxMark_q <= dbus.w_data[CW-1:0];
`ifdef SPI_ERR_IRQ_EN
                    A_IE:      ie_q <= dbus.w_data[3:0];
`else
                    A_IE:      ie_q <= {2'b00, dbus.w_data[1:0]};
`endif
                    default: ;
                endcase
            end
        end
    end

    // Live config copies: re-load from the shadows on every cycle the
    // controller (or, for chip selects, the CS lines) allow it, so a write
    // made while frozen is applied on the first free cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sckDiv_q  <= 12'h003;
            sckMode_q <= 2'b00;
            delay0_q  <= 16'h0101;
            delay1_q  <= 16'h0001;
            fmtLen_q  <= 4'd8;
            fmtDir_q  <= 1'b0;
            rxDis_q   <= 1'b0;
            csId_q    <= '0;
            csDef_q   <= '1;
            csMode_q  <= 2'b00;
        end else begin
            if (!spi_busy_i) begin
                sckDiv_q  <= sckDivSh_q;
                sckMode_q <= sckModeSh_q;
                delay0_q  <= delay0Sh_q;
                delay1_q  <= delay1Sh_q;
                fmtLen_q  <= fmtLenSh_q;
                fmtDir_q  <= fmtDirSh_q;
                rxDis_q   <= rxDisSh_q;
            end
            if (spi_hold_off_i) begin
                csId_q   <= csIdSh_q;
                csDef_q  <= csDefSh_q;
                csMode_q <= csModeSh_q;
            end
        end
    end

    // Circular FIFOs: pointers wrap naturally at the power-of-two depth,
    // counts are kept separately so full and empty are distinguishable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                txMem_q[i] <= '0;
                rxMem_q[i] <= '0;
            end
            txWr_q    <= '0;
            txRd_q    <= '0;
            txCount_q <= '0;
            rxWr_q    <= '0;
            rxRd_q    <= '0;
            rxCount_q <= '0;
        end else begin
            if (txPush) begin
                txMem_q[txWr_q] <= dbus.w_data[7:0];
                txWr_q          <= txWr_q + 1'b1;
            end
            if (txPop) txRd_q <= txRd_q + 1'b1;
            case ({txPush, txPop})
                2'b10:   txCount_q <= txCount_q + 1'b1;
                2'b01:   txCount_q <= txCount_q - 1'b1;
                default: ;
            endcase
            if (rxPush) begin
                rxMem_q[rxWr_q] <= rx_data_i;
                rxWr_q          <= rxWr_q + 1'b1;
            end
            if (rxPop) rxRd_q <= rxRd_q + 1'b1;
            case ({rxPush, rxPop})
                2'b10:   rxCount_q <= rxCount_q + 1'b1;
                2'b01:   rxCount_q <= rxCount_q - 1'b1;
                default: ;
            endcase
        end
    end

    assign dbus.ack     = ack_q;
    assign dbus.r_data  = rData_q;
    assign irq_o        = irq_q;
    assign tx_data_o    = txMem_q[txRd_q];
    assign tx_empty_o   = txEmpty;
    assign rx_full_o    = rxFull;
    assign sck_div_o    = sckDiv_q;
    assign sck_pha_o    = sckMode_q[0];
    assign sck_pol_o    = sckMode_q[1];
    assign cs_id_o      = csId_q;
    assign cs_def_o     = csDef_q;
    assign cs_mode_o    = csMode_q;
    assign delay0_o     = delay0_q;
    assign delay1_o     = delay1_q;
    assign frame_len_o  = fmtLen_q;
    assign shift_dir_o  = fmtDir_q;
    assign rx_disable_o = rxDis_q;

endmodule

// File: tb/tb_spi_regs_fifo.sv
// ----------------------------------------------------------------------------
// tb_spi_regs_fifo
//   Self-checking bench for spi_regs_fifo: directed scenarios with literal
//   expectations, then randomized traffic compared every cycle against a
//   queue-based behavioural model of the register block.
// ----------------------------------------------------------------------------
module tb_spi_regs_fifo;

    localparam int NUM_CS     = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int CSW        = 2;

    logic              clk;
    logic              rst_n;
    logic              spiSel;
    logic              irq;
    logic              busy, holdOff, txPop, rxPush;
    logic [7:0]        rxData, txData;
    logic              txEmpty, rxFull;
    logic [11:0]       sckDiv;
    logic              sckPha, sckPol;
    logic [CSW-1:0]    csId;
    logic [NUM_CS-1:0] csDef;
    logic [1:0]        csMode;
    logic [15:0]       delay0, delay1;
    logic [3:0]        frameLen;
    logic              shiftDir, rxDisable;

    int errors = 0;
    int checks = 0;

    spi_regs_fifo_if busIf ();

    spi_regs_fifo #(.NUM_CS(NUM_CS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .spi_sel_i(spiSel), .dbus(busIf), .irq_o(irq),
        .spi_busy_i(busy), .spi_hold_off_i(holdOff),
        .tx_pop_i(txPop), .tx_data_o(txData), .tx_empty_o(txEmpty),
        .rx_push_i(rxPush), .rx_data_i(rxData), .rx_full_o(rxFull),
        .sck_div_o(sckDiv), .sck_pha_o(sckPha), .sck_pol_o(sckPol),
        .cs_id_o(csId), .cs_def_o(csDef), .cs_mode_o(csMode),
        .delay0_o(delay0), .delay1_o(delay1), .frame_len_o(frameLen),
        .shift_dir_o(shiftDir), .rx_disable_o(rxDisable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic        mAck, mIrq;
    logic [31:0] mRdata;
    logic [31:0] shSckDiv, oSckDiv, shMode, oMode, shD0, oD0, shD1, oD1;
    logic [31:0] shLen, oLen, shDir, oDir, shRxDis, oRxDis;
    logic [31:0] shCsId, oCsId, shCsDef, oCsDef, shCsMode, oCsMode;
    int          txMark, rxMark;
    logic [3:0]  mIe;
    logic        txOvf, rxOvf;
    logic [7:0]  txQ[$];
    logic [7:0]  rxQ[$];

    logic [7:0] addrTable [15] = '{8'h00, 8'h04, 8'h10, 8'h14, 8'h18, 8'h28, 8'h2C,
                                   8'h40, 8'h48, 8'h4C, 8'h50, 8'h54, 8'h70, 8'h74, 8'h3C};

    function automatic logic [3:0] modelIp();
        return {rxOvf, txOvf, rxQ.size() > rxMark, txQ.size() < txMark};
    endfunction

    function automatic logic [31:0] modelRead(input logic [7:0] a);
        case (a)
            8'h00: return shSckDiv;
            8'h04: return shMode;
            8'h10: return shCsId;
            8'h14: return shCsDef;
            8'h18: return shCsMode;
            8'h28: return {8'h00, shD0[15:8], 8'h00, shD0[7:0]};
            8'h2C: return {8'h00, shD1[15:8], 8'h00, shD1[7:0]};
            8'h40: return (shLen << 16) | (shRxDis << 3) | (shDir << 2);
            8'h48: return (txQ.size() == FIFO_DEPTH) ? 32'h8000_0000 : 32'h0;
            8'h4C: return (rxQ.size() == 0) ? 32'h8000_0000 : 32'(rxQ[0]);
            8'h50: return 32'(txMark);
            8'h54: return 32'(rxMark);
            8'h70: return 32'(mIe);
            8'h74: return 32'(modelIp());
            default: return 32'h0;
        endcase
    endfunction

    task automatic modelReset();
        mAck = 0; mIrq = 0; mRdata = 0;
        shSckDiv = 3; oSckDiv = 3; shMode = 0; oMode = 0;
        shD0 = 32'h0101; oD0 = 32'h0101; shD1 = 1; oD1 = 1;
        shLen = 8; oLen = 8; shDir = 0; oDir = 0; shRxDis = 0; oRxDis = 0;
        shCsId = 0; oCsId = 0; shCsDef = (1 << NUM_CS) - 1; oCsDef = (1 << NUM_CS) - 1;
        shCsMode = 0; oCsMode = 0;
        txMark = 0; rxMark = 0; mIe = 0; txOvf = 0; rxOvf = 0;
        txQ.delete(); rxQ.delete();
    endtask

    task automatic modelStep();
        logic        acc, wen, irqN, txW, rxR, txOk, rxOk;
        logic [7:0]  a;
        logic [31:0] w, rd;
        irqN = |(mIe & modelIp());
        acc  = busIf.req & spiSel & !mAck;
        wen  = busIf.w_en;
        a    = busIf.addr[7:0];
        w    = busIf.w_data;
        rd   = (acc && !wen) ? modelRead(a) : 32'h0;
        txW  = acc && wen && a == 8'h48;
        rxR  = acc && !wen && a == 8'h4C;
        txOk = txQ.size() < FIFO_DEPTH;
        rxOk = rxQ.size() < FIFO_DEPTH;
        if (!busy) begin
            oSckDiv = shSckDiv; oMode = shMode; oD0 = shD0; oD1 = shD1;
            oLen = shLen; oDir = shDir;
        end
        if (rxPush && rxOk && !oRxDis) rxQ.push_back(rxData);
        else if (rxPush && !oRxDis) begin
`ifdef SPI_ERR_IRQ_EN
            rxOvf = 1;
`endif
        end
        if (!busy) oRxDis = shRxDis;
        if (holdOff) begin
            oCsId = shCsId; oCsDef = shCsDef; oCsMode = shCsMode;
        end
        if (rxR && rxQ.size() > 0 && !(rxPush && rxOk && !oRxDis && rxQ.size() == 1 && 0)) begin
            void'(rxQ.pop_front());
        end
        if (txPop && txQ.size() > 0) begin
            if (txW && txOk) txQ.push_back(w[7:0]);
            void'(txQ.pop_front());
        end else if (txW && txOk) txQ.push_back(w[7:0]);
        if (acc && wen) begin
            case (a)
                8'h00: shSckDiv = w & 32'hFFF;
                8'h04: shMode   = w & 32'h3;
                8'h10: shCsId   = w % NUM_CS;
                8'h14: shCsDef  = w & ((1 << NUM_CS) - 1);
                8'h18: shCsMode = w & 32'h3;
                8'h28: shD0     = {16'h0, w[23:16], w[7:0]};
                8'h2C: shD1     = {16'h0, w[23:16], w[7:0]};
                8'h40: begin shLen = (w >> 16) & 32'hF; shRxDis = w[3]; shDir = w[2]; end
                8'h50: txMark = int'(w & 32'hF);
                8'h54: rxMark = int'(w & 32'hF);
`ifdef SPI_ERR_IRQ_EN
                8'h70: mIe = w[3:0];
                8'h74: begin if (w[2]) txOvf = 0; if (w[3]) rxOvf = 0; end
`else
                8'h70: mIe = {2'b00, w[1:0]};
`endif
                default: ;
            endcase
        end
`ifdef SPI_ERR_IRQ_EN
        if (txW && !txOk) txOvf = 1;
`endif
        mAck = acc; mRdata = rd; mIrq = irqN;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) modelReset();
        else        modelStep();
    end

    // ---------------- checking ----------------
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            checkOutput("ack", 32'(busIf.ack), 32'(mAck));
            if (mAck) checkOutput("rData", busIf.r_data, mRdata);
            checkOutput("irq", 32'(irq), 32'(mIrq));
            checkOutput("txEmpty", 32'(txEmpty), 32'(txQ.size() == 0));
            if (txQ.size() > 0) checkOutput("txHead", 32'(txData), 32'(txQ[0]));
            checkOutput("rxFull", 32'(rxFull), 32'(rxQ.size() == FIFO_DEPTH));
            checkOutput("sckDiv", 32'(sckDiv), oSckDiv);
            checkOutput("sckMode", 32'({sckPol, sckPha}), oMode);
            checkOutput("csId", 32'(csId), oCsId);
            checkOutput("csDef", 32'(csDef), oCsDef);
            checkOutput("csMode", 32'(csMode), oCsMode);
            checkOutput("delay0", 32'(delay0), oD0);
            checkOutput("delay1", 32'(delay1), oD1);
            checkOutput("fmtLen", 32'(frameLen), oLen);
            checkOutput("fmtDir", 32'(shiftDir), oDir);
            checkOutput("rxDisable", 32'(rxDisable), oRxDis);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic busAccess(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                             output logic [31:0] rd);
        busIf.req = 1; spiSel = 1; busIf.w_en = wr; busIf.addr = {24'h0, a}; busIf.w_data = wd;
        @(negedge clk);
        checkOutput("ackLatency", 32'(busIf.ack), 32'd1);
        rd = busIf.r_data;
        busIf.req = 0; spiSel = 0;
        @(negedge clk);
    endtask

    task automatic busWrite(input logic [7:0] a, input logic [31:0] wd);
        logic [31:0] dummy;
        busAccess(1'b1, a, wd, dummy);
    endtask

    task automatic applyStimulus(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (c == cycles / 2) begin
                rst_n = 0;
                #1;
                checkOutput("randResetTxEmpty", 32'(txEmpty), 32'd1);
            end else rst_n = 1;
            spiSel       = ($urandom_range(0, 3) != 0);
            busIf.req    = $urandom_range(0, 1);
            busIf.w_en   = $urandom_range(0, 1);
            busIf.addr   = {24'h0, addrTable[$urandom_range(0, 14)]};
            busIf.w_data = $urandom();
            busy         = ($urandom_range(0, 2) == 0);
            holdOff      = $urandom_range(0, 1);
            txPop        = ($urandom_range(0, 2) == 0);
            rxPush       = $urandom_range(0, 1);
            rxData       = 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        busIf.req = 0; spiSel = 0; txPop = 0; rxPush = 0; busy = 0; rst_n = 1;
    endtask

    // ---------------- directed sequence then random traffic ----------------
    initial begin
        logic [31:0] rd;
        rst_n = 0; spiSel = 0; busy = 0; holdOff = 1; txPop = 0; rxPush = 0; rxData = 0;
        busIf.req = 0; busIf.w_en = 0; busIf.addr = 0; busIf.w_data = 0;
        repeat (3) @(negedge clk);
        checkOutput("resetIrq", 32'(irq), 32'd0);
        checkOutput("resetTxEmpty", 32'(txEmpty), 32'd1);
        rst_n = 1;
        @(negedge clk);

        busAccess(1'b0, 8'h00, 0, rd); checkOutput("rdSckDiv", rd, 32'h003);
        busAccess(1'b0, 8'h14, 0, rd); checkOutput("rdCsDef", rd, 32'h0000000F);
        busAccess(1'b0, 8'h28, 0, rd); checkOutput("rdDelay0", rd, 32'h00010001);
        busAccess(1'b0, 8'h40, 0, rd); checkOutput("rdFmt", rd, 32'h00080000);

        busy = 1;
        busWrite(8'h00, 32'h010);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("busyFrozen", 32'(sckDiv), 32'h003);
        end
        busAccess(1'b0, 8'h00, 0, rd); checkOutput("rdShadow", rd, 32'h010);
        busy = 0;
        @(negedge clk);
        checkOutput("busyReleased", 32'(sckDiv), 32'h010);

        for (int i = 1; i <= FIFO_DEPTH + 1; i++) busWrite(8'h48, 32'(i));
        checkOutput("txNotEmpty", 32'(txEmpty), 32'd0);
        busAccess(1'b0, 8'h48, 0, rd); checkOutput("txFullFlag", rd, 32'h8000_0000);
`ifdef SPI_ERR_IRQ_EN
        busAccess(1'b0, 8'h74, 0, rd); checkOutput("txOvfSet", rd & 32'h4, 32'h4);
        busWrite(8'h74, 32'h4);
        busAccess(1'b0, 8'h74, 0, rd); checkOutput("txOvfClr", rd & 32'h4, 32'h0);
`endif
        for (int k = 1; k <= FIFO_DEPTH; k++) begin
            checkOutput("txPopSeq", 32'(txData), 32'(k));
            txPop = 1;
            @(negedge clk);
        end
        txPop = 0;
        checkOutput("txDrained", 32'(txEmpty), 32'd1);

        busWrite(8'h54, 32'd2);
        busWrite(8'h70, 32'h2);
        for (int i = 0; i < 3; i++) begin
            rxPush = 1; rxData = 8'hA1 + 8'(i);
            @(negedge clk);
        end
        rxPush = 0;
        @(negedge clk);
        checkOutput("rxWmIrq", 32'(irq), 32'd1);
        busAccess(1'b0, 8'h4C, 0, rd); checkOutput("rxFirst", rd, 32'h0000_00A1);
        checkOutput("rxIrqDrop", 32'(irq), 32'd0);
        busAccess(1'b0, 8'h4C, 0, rd); checkOutput("rxSecond", rd, 32'h0000_00A2);
        busAccess(1'b0, 8'h4C, 0, rd); checkOutput("rxThird", rd, 32'h0000_00A3);
        busAccess(1'b0, 8'h4C, 0, rd); checkOutput("rxEmptyRead", rd, 32'h8000_0000);
        busAccess(1'b0, 8'h4C, 0, rd); checkOutput("rxStillEmpty", rd, 32'h8000_0000);

        for (int i = 0; i < 4; i++) busWrite(8'h48, 32'h11 + 32'(i));
        busIf.req = 1; spiSel = 1; busIf.w_en = 1; busIf.addr = 32'h48; busIf.w_data = 32'h15;
        txPop = 1;
        @(negedge clk);
        txPop = 0; busIf.req = 0; spiSel = 0;
        @(negedge clk);
        checkOutput("pushPopHead", 32'(txData), 32'h12);

        rxPush = 1; rxData = 8'h5A;
        @(negedge clk);
        rxPush = 0;
        #2 rst_n = 0;
        #1;
        checkOutput("asyncTxEmpty", 32'(txEmpty), 32'd1);
        checkOutput("asyncSckDiv", 32'(sckDiv), 32'h003);
        checkOutput("asyncDelay0", 32'(delay0), 32'h0101);
        checkOutput("asyncIrq", 32'(irq), 32'd0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        applyStimulus(3000);
        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
